// File: rtl/pc_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stage_pkg
//  Purpose  : Shared next-PC select encoding and helpers for the PC stage
//  Revision : 1.0 - initial release
// ============================================================================
package pc_stage_pkg;

  localparam int PC_W      = 16;
  localparam int RAS_CNT_W = 4;

  // Encoding of the select driven into the next-PC multiplexer
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_JMP = 2'b10,
    NPC_RET = 2'b11
  } npc_sel_e;

  // Redirect priority: return beats jump/call, which beat a taken branch
  function automatic npc_sel_e select_npc(input logic ret,
                                          input logic jump,
                                          input logic call,
                                          input logic br_taken);
    if (ret)              return NPC_RET;
    else if (jump | call) return NPC_JMP;
    else if (br_taken)    return NPC_BR;
    else                  return NPC_SEQ;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_16b.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_16b
//  Purpose  : 4-to-1 multiplexer, 16-bit data
//  Revision : 1.0 - initial release
// ============================================================================
module mux4_16b
  import pc_stage_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  output logic [15:0] y
);

  // Pure selection, default to input a
  always_comb begin
    y = a;
    case (sel)
      NPC_SEQ: y = a;
      NPC_BR:  y = b;
      NPC_JMP: y = c;
      NPC_RET: y = d;
      default: y = a;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pc_stage
//  Purpose  : Program counter with sequential/branch/jump/return next-PC
//             selection and a circular return-address stack
//  Revision : 1.0 - initial release
// ============================================================================
module pc_stage
  import pc_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_INC    = 16'd2,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        jump,
  input  logic        call,
  input  logic [15:0] jump_target,
  input  logic        ret,
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic [1:0]  npc_sel,
  output logic [3:0]  ras_count,
  output logic        ras_ovf,
  output logic        ras_unf
);

  // Depth is a power of two, so pointer wrap is the natural binary wrap
  localparam int              PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [3:0]      RAS_FULL = 4'(RAS_DEPTH);

  logic [15:0]      ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_m1;
  logic             ras_empty;
  logic             ras_full;
  logic [15:0]      ret_addr;
  logic [15:0]      npc;
  logic             push;
  npc_sel_e         sel;

  assign pc_plus   = pc + PC_INC;
  assign top_m1    = top - PTR_ONE;
  assign ras_empty = (ras_count == 4'd0);
  assign ras_full  = (ras_count == RAS_FULL);

  // An empty stack returns to the reset vector instead of stale data
  assign ret_addr  = ras_empty ? RESET_PC : ras_mem[top_m1];

  // A return in the same cycle as a call suppresses the push
  assign push      = call & ~ret;

  assign sel       = select_npc(ret, jump, call, br_taken);
  assign npc_sel   = sel;

  mux4_16b u_npc_mux (
    .sel (sel),
    .a   (pc_plus),
    .b   (br_target),
    .c   (jump_target),
    .d   (ret_addr),
    .y   (npc)
  );

  // PC, stack pointer, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      top       <= '0;
      ras_count <= 4'd0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (!stall) begin
      pc <= npc;
      if (ret) begin
        if (!ras_empty) begin
          top       <= top_m1;
          ras_count <= ras_count - 4'd1;
        end else begin
          ras_unf   <= 1'b1;
        end
      end else if (push) begin
        // When full, top already points at the oldest entry, so it is overwritten
        top <= top + PTR_ONE;
        if (ras_full) ras_ovf   <= 1'b1;
        else          ras_count <= ras_count + 4'd1;
      end
    end
  end

  // Stack storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (!reset && !stall && push) begin
      ras_mem[top] <= pc_plus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_stage
//  Purpose  : Self-checking bench for pc_stage with a queue-based reference
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        jump;
  logic        call;
  logic [15:0] jump_target;
  logic        ret;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic [1:0]  npc_sel;
  logic [3:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];

  // Reference: stack kept as a queue, oldest at front
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_ovf;
  logic        m_unf;

  pc_stage #(
    .RESET_PC  (16'h0000),
    .PC_INC    (16'd2),
    .RAS_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .call        (call),
    .jump_target (jump_target),
    .ret         (ret),
    .pc          (pc),
    .pc_plus     (pc_plus),
    .npc_sel     (npc_sel),
    .ras_count   (ras_count),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_state();
    exp_t e;
    e = sb.pop_front();
    check("pc",        pc,                e.pc);
    check("ras_count", 16'(ras_count),    16'(e.cnt));
    check("ras_ovf",   16'(ras_ovf),      16'(e.ovf));
    check("ras_unf",   16'(ras_unf),      16'(e.unf));
    check("pc_plus",   pc_plus,           e.pc + 16'd2);
  endtask

  task automatic push_expected();
    exp_t e;
    e.pc  = m_pc;
    e.cnt = 4'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge
  task automatic do_reset(input logic st, input logic r, input logic c);
    reset = 1'b1; stall = st; ret = r; call = c;
    br_taken = 1'b0; jump = 1'b0;
    m_pc = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    push_expected();
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0; ret = 1'b0; call = 1'b0;
    compare_state();
    @(negedge clk);
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] bt,
                      input logic j, input logic [15:0] jt,
                      input logic c, input logic r);
    logic [1:0]  es;
    logic [15:0] dummy;
    reset = 1'b0; stall = st; br_taken = br; br_target = bt;
    jump = j; jump_target = jt; call = c; ret = r;
    es = r ? 2'b11 : ((j | c) ? 2'b10 : (br ? 2'b01 : 2'b00));
    #1 check("npc_sel", 16'(npc_sel), 16'(es));
    if (!st) begin
      if (r) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_pc  = 16'h0000;
          m_unf = 1'b1;
        end
      end else if (j | c) begin
        if (c) begin
          if (m_stk.size() == 4) begin
            dummy = m_stk.pop_front();
            m_ovf = 1'b1;
          end
          m_stk.push_back(m_pc + 16'd2);
        end
        m_pc = jt;
      end else if (br) begin
        m_pc = bt;
      end else begin
        m_pc = m_pc + 16'd2;
      end
    end
    push_expected();
    @(posedge clk); #1;
    compare_state();
    @(negedge clk);
  endtask

  task automatic seq_op();                   step(0, 0, 16'h0, 0, 16'h0, 0, 0); endtask
  task automatic jmp_op(input logic [15:0] t);  step(0, 0, 16'h0, 1, t, 0, 0); endtask
  task automatic call_op(input logic [15:0] t); step(0, 0, 16'h0, 0, t, 1, 0); endtask
  task automatic ret_op();                   step(0, 0, 16'h0, 0, 16'h0, 0, 1); endtask

  logic [15:0] rets [4];

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    jump = 1'b0; call = 1'b0; jump_target = '0; ret = 1'b0;
    m_pc = '0; m_ovf = 1'b0; m_unf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state and free-running increment
    do_reset(0, 0, 0);
    check("reset_pc", pc, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      seq_op();
      check("seq_pc", pc, 16'(2 * i));
    end
    repeat (4) seq_op();
    check("at_0010", pc, 16'h0010);

    // Jump outranks a taken branch in the same cycle
    step(0, 1, 16'h0100, 1, 16'h0200, 0, 0);
    check("br_vs_jmp", pc, 16'h0200);

    // Call and matching return
    jmp_op(16'h0020);
    call_op(16'h0300);
    check("call_cnt", 16'(ras_count), 16'd1);
    repeat (3) seq_op();
    check("at_0306", pc, 16'h0306);
    ret_op();
    check("ret_pc", pc, 16'h0022);
    check("ret_cnt", 16'(ras_count), 16'd0);

    // Overflow on fifth call, then drain and underflow
    for (int i = 0; i < 5; i++) begin
      jmp_op(16'h0040 + 16'(i * 16));
      call_op(16'h1000);
    end
    check("ovf_flag", 16'(ras_ovf), 16'd1);
    check("ovf_cnt", 16'(ras_count), 16'd4);
    rets[0] = 16'h0082; rets[1] = 16'h0072; rets[2] = 16'h0062; rets[3] = 16'h0052;
    for (int i = 0; i < 4; i++) begin
      ret_op();
      check("drain_pc", pc, rets[i]);
    end
    ret_op();
    check("unf_pc", pc, 16'h0000);
    check("unf_flag", 16'(ras_unf), 16'd1);

    // Stall holds everything even with call asserted
    repeat (3) step(1, 0, 16'h0, 0, 16'h0400, 1, 0);
    check("stall_pc", pc, 16'h0000);
    check("stall_cnt", 16'(ras_count), 16'd0);
    call_op(16'h0400);
    check("release_cnt", 16'(ras_count), 16'd1);

    // Return with call in same cycle: pop only
    step(0, 0, 16'h0, 0, 16'h0700, 1, 1);
    check("retcall_pc", pc, 16'h0002);
    check("retcall_cnt", 16'(ras_count), 16'd0);

    // Reset wins over stall and ret
    call_op(16'h0500);
    do_reset(1, 1, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_cnt", 16'(ras_count), 16'd0);
    check("rst_flags", {14'd0, ras_ovf, ras_unf}, 16'd0);

    // Sequential wrap at the top of the address space
    jmp_op(16'hFFFC);
    seq_op();
    seq_op();
    check("wrap_pc", pc, 16'h0000);

    // Random mix against the reference
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), 16'($urandom) & 16'hFFFE,
           ($urandom_range(0, 5) == 0), 16'($urandom) & 16'hFFFE,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
